// File: rtl/jtframe_lfbuf_avl_ctrl.sv
// Line-buffer to Avalon-MM DDR bridge: stores a completed line RAM to DDR and
// fetches lines back into the display line RAM, double-buffered by frame.
module jtframe_lfbuf_avl_ctrl #(
  parameter int unsigned AW = 24,
  parameter int unsigned LW = 6,
  parameter int unsigned BL = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          wr_req,
  input  logic [7:0]    wr_row,
  input  logic          rd_req,
  input  logic [7:0]    rd_row,
  output logic [LW-1:0] lr_addr,
  input  logic [63:0]   lr_data,
  output logic [LW-1:0] lw_addr,
  output logic [63:0]   lw_data,
  output logic          lw_we,
  input  logic          avl_ready,
  output logic          avl_burstbegin,
  output logic [AW-1:0] avl_addr,
  output logic [3:0]    avl_size,
  output logic          avl_read_req,
  output logic          avl_write_req,
  output logic [63:0]   avl_wdata,
  output logic [7:0]    avl_be,
  input  logic [63:0]   avl_rdata,
  input  logic          avl_rdata_valid,
  input  logic          init_done,
  output logic          wr_done,
  output logic          rd_done,
  output logic          busy,
  output logic [7:0]    st_dout
);

  typedef enum logic [2:0] {WAIT_INIT, IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

  localparam logic [LW-1:0] BMASK = LW'(BL - 1);

  state_t        st;
  logic          frm, vs_l, cur_frm;
  logic [7:0]    cur_row, wr_row_l, rd_row_l;
  logic          wr_pend, rd_pend;
  logic [3:0]    wr_ovr, rd_ovr;
  logic [LW-1:0] cnt, cnt_nx;
  logic          cnt_last, burst_end, wr_acc, wr_drop, rd_drop;

  function automatic logic [AW-1:0] mk_addr(input logic f, input logic [7:0] r,
                                            input logic [LW-1:0] w);
    return AW'({f, r, w});
  endfunction

  assign cnt_nx    = cnt + LW'(1);
  assign cnt_last  = cnt == {LW{1'b1}};
  assign burst_end = (cnt_nx & BMASK) == '0;
  assign wr_acc    = (st == WR_BURST) && avl_write_req && avl_ready;
  assign wr_drop   = wr_req && (wr_pend || st == WR_BURST);
  assign rd_drop   = rd_req && (rd_pend || st == RD_CMD || st == RD_DATA);

  // Look-ahead read address keeps lr_data one word ahead of each accepted beat
  assign lr_addr   = cnt + LW'(wr_acc);
  assign avl_wdata = (st == WR_BURST) ? lr_data : '0;
  assign lw_we     = !rst && (st == RD_DATA) && avl_rdata_valid;
  assign lw_data   = lw_we ? avl_rdata : '0;
  assign lw_addr   = lw_we ? cnt : '0;
  assign avl_size  = 4'(BL);
  assign avl_be    = 8'hFF;
  assign st_dout   = {wr_ovr, rd_ovr};

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= WAIT_INIT;
      frm            <= 1'b0;
      vs_l           <= 1'b0;
      cur_frm        <= 1'b0;
      cur_row        <= '0;
      wr_row_l       <= '0;
      rd_row_l       <= '0;
      wr_pend        <= 1'b0;
      rd_pend        <= 1'b0;
      wr_ovr         <= '0;
      rd_ovr         <= '0;
      cnt            <= '0;
      avl_addr       <= '0;
      avl_burstbegin <= 1'b0;
      avl_read_req   <= 1'b0;
      avl_write_req  <= 1'b0;
      wr_done        <= 1'b0;
      rd_done        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      vs_l    <= vs;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (vs && !vs_l) frm <= ~frm;

      // Request capture; duplicates are dropped and counted
      if (wr_req && !wr_drop) begin
        wr_pend  <= 1'b1;
        wr_row_l <= wr_row;
      end
      if (rd_req && !rd_drop) begin
        rd_pend  <= 1'b1;
        rd_row_l <= rd_row;
      end
      if (wr_drop && wr_ovr != 4'hF) wr_ovr <= wr_ovr + 4'd1;
      if (rd_drop && rd_ovr != 4'hF) rd_ovr <= rd_ovr + 4'd1;

      case (st)
        WAIT_INIT: if (init_done) st <= IDLE;
        IDLE: begin
          if (rd_pend) begin
            rd_pend        <= 1'b0;
            cur_row        <= rd_row_l;
            cur_frm        <= ~frm;
            cnt            <= '0;
            avl_addr       <= mk_addr(~frm, rd_row_l, '0);
            avl_read_req   <= 1'b1;
            avl_burstbegin <= 1'b1;
            busy           <= 1'b1;
            st             <= RD_CMD;
          end else if (wr_pend) begin
            wr_pend  <= 1'b0;
            cur_row  <= wr_row_l;
            cur_frm  <= frm;
            cnt      <= '0;
            avl_addr <= mk_addr(frm, wr_row_l, '0);
            busy     <= 1'b1;
            st       <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (!avl_write_req) begin
            avl_write_req  <= 1'b1;
            avl_burstbegin <= 1'b1;
          end else if (avl_ready) begin
            cnt <= cnt_nx;
            if (cnt_last) begin
              avl_write_req  <= 1'b0;
              avl_burstbegin <= 1'b0;
              wr_done        <= 1'b1;
              busy           <= 1'b0;
              st             <= IDLE;
            end else begin
              avl_burstbegin <= burst_end;
              if (burst_end) avl_addr <= mk_addr(cur_frm, cur_row, cnt_nx);
            end
          end
        end
        RD_CMD: begin
          if (avl_ready) begin
            avl_read_req   <= 1'b0;
            avl_burstbegin <= 1'b0;
            st             <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (avl_rdata_valid) begin
            cnt <= cnt_nx;
            if (burst_end) begin
              if (cnt_last) begin
                rd_done <= 1'b1;
                busy    <= 1'b0;
                st      <= IDLE;
              end else begin
                avl_addr       <= mk_addr(cur_frm, cur_row, cnt_nx);
                avl_read_req   <= 1'b1;
                avl_burstbegin <= 1'b1;
                st             <= RD_CMD;
              end
            end
          end
        end
        default: st <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_lfbuf_avl_ctrl.sv
// Directed bench for jtframe_lfbuf_avl_ctrl with a line RAM and a fixed-latency
// Avalon read model.
module tb_jtframe_lfbuf_avl_ctrl;
  localparam int unsigned AW = 24, LW = 6, BL = 8, L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vs, wr_req, rd_req, avl_ready, avl_rdata_valid, init_done;
  logic [7:0]    wr_row, rd_row;
  logic [LW-1:0] lr_addr, lw_addr;
  logic [63:0]   lr_data, lw_data, avl_wdata, avl_rdata;
  logic          lw_we, avl_burstbegin, avl_read_req, avl_write_req;
  logic [AW-1:0] avl_addr;
  logic [3:0]    avl_size;
  logic [7:0]    avl_be, st_dout;
  logic          wr_done, rd_done, busy;

  jtframe_lfbuf_avl_ctrl #(.AW(AW), .LW(LW), .BL(BL)) dut (
    .clk(clk), .rst(rst), .vs(vs),
    .wr_req(wr_req), .wr_row(wr_row), .rd_req(rd_req), .rd_row(rd_row),
    .lr_addr(lr_addr), .lr_data(lr_data),
    .lw_addr(lw_addr), .lw_data(lw_data), .lw_we(lw_we),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_size(avl_size), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid), .init_done(init_done),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy), .st_dout(st_dout)
  );

  // Source line RAM with one-cycle read latency
  logic [63:0] lr_mem [64];
  always @(posedge clk) lr_data <= lr_mem[lr_addr];

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdata(input logic [23:0] a);
    return {8'hA5, a, 8'h3C, ~a};
  endfunction

  int cyc = 0, wr_beats, wr_bb, rd_cmds, lw_cnt, wr_dones, rd_dones, busy_cyc;
  int first_rd_cmd, first_wr_beat;
  logic [23:0] wr_base, rd_base, cmd_addr, beat_addr;
  int rd_left = 0, cmd_cyc = 0;
  bit have_cmd = 1'b0, rnd_ready = 1'b0;

  task automatic clear_mon();
    wr_beats = 0; wr_bb = 0; rd_cmds = 0; lw_cnt = 0;
    wr_dones = 0; rd_dones = 0; busy_cyc = 0;
    first_rd_cmd = -1; first_wr_beat = -1;
  endtask

  // One clock: drive inputs at negedge, then check settled outputs
  task automatic tick();
    @(negedge clk);
    cyc++;
    avl_ready       = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    avl_rdata_valid = 1'b0;
    avl_rdata       = '0;
    if (rd_left == 0 && have_cmd && cyc == cmd_cyc + L + 1) begin
      have_cmd  = 1'b0;
      rd_left   = BL;
      beat_addr = cmd_addr;
    end
    if (rd_left > 0) begin
      avl_rdata_valid = 1'b1;
      avl_rdata       = mdata(beat_addr);
      beat_addr++;
      rd_left--;
    end
    #1;
    if (avl_read_req && avl_ready) begin
      chk("rd_cmd_addr", 64'(avl_addr), 64'(rd_base + 24'(rd_cmds * BL)));
      chk("rd_cmd_bb", 64'(avl_burstbegin), 64'(1));
      if (first_rd_cmd < 0) first_rd_cmd = cyc;
      rd_cmds++;
      have_cmd = 1'b1;
      cmd_cyc  = cyc;
      cmd_addr = avl_addr;
    end
    if (lw_we) begin
      chk("lw_addr", 64'(lw_addr), 64'(lw_cnt));
      chk("lw_data", lw_data, mdata(rd_base + 24'(lw_cnt)));
      lw_cnt++;
    end
    if (avl_write_req && avl_ready) begin
      chk("wr_data", avl_wdata, lr_mem[wr_beats % 64]);
      chk("wr_bb", 64'(avl_burstbegin), 64'((wr_beats % BL) == 0));
      if (avl_burstbegin) begin
        chk("wr_addr", 64'(avl_addr), 64'(wr_base + 24'(wr_beats)));
        wr_bb++;
      end
      if (first_wr_beat < 0) first_wr_beat = cyc;
      wr_beats++;
    end
    wr_dones += int'(wr_done);
    rd_dones += int'(rd_done);
    busy_cyc += int'(busy);
  endtask

  task automatic pulse_wr(input logic [7:0] r);
    wr_req = 1'b1; wr_row = r;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] r);
    rd_req = 1'b1; rd_row = r;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic run_until(input bit wr, input int budget);
    int n = 0;
    while ((wr ? wr_dones : rd_dones) == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(wr ? "wr_done_timeout" : "rd_done_timeout", 64'(n < budget), 64'(1));
  endtask

  task automatic chk_reset();
    chk("rst_be", 64'(avl_be), 64'hFF);
    chk("rst_size", 64'(avl_size), 64'(8));
    chk("rst_addr", 64'(avl_addr), 64'(0));
    chk("rst_strobes", 64'({avl_burstbegin, avl_read_req, avl_write_req, lw_we,
                            wr_done, rd_done, busy}), 64'(0));
    chk("rst_st_dout", 64'(st_dout), 64'(0));
    chk("rst_lr_addr", 64'(lr_addr), 64'(0));
    chk("rst_lw_addr", 64'(lw_addr), 64'(0));
    chk("rst_lw_data", lw_data, 64'(0));
    chk("rst_wdata", avl_wdata, 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) lr_mem[i] = {32'hCAFE_0000 | 32'(i), 32'(i * i + 7)};
    rst = 1'b1; vs = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_row = '0; rd_row = '0;
    avl_ready = 1'b1; avl_rdata_valid = 1'b0; avl_rdata = '0; init_done = 1'b1;
    clear_mon();
    wr_base = '0; rd_base = '0; cmd_addr = '0; beat_addr = '0;
    repeat (3) tick();
    chk_reset();
    rst = 1'b0;
    repeat (3) tick();

    // Write row 5, frame 0
    clear_mon(); wr_base = 24'h000140;
    pulse_wr(8'd5);
    run_until(1'b1, 200);
    chk("wr1_beats", 64'(wr_beats), 64'(64));
    chk("wr1_bursts", 64'(wr_bb), 64'(8));
    chk("wr1_latency", 64'(busy_cyc), 64'(65));
    tick();
    chk("wr1_done_once", 64'(wr_dones), 64'(1));

    // Read row 3 from the other frame
    clear_mon(); rd_base = 24'h0040C0;
    pulse_rd(8'd3);
    run_until(1'b0, 300);
    chk("rd1_cmds", 64'(rd_cmds), 64'(8));
    chk("rd1_beats", 64'(lw_cnt), 64'(64));
    chk("rd1_latency", 64'(busy_cyc), 64'(104));
    tick();
    chk("rd1_done_once", 64'(rd_dones), 64'(1));

    // Simultaneous requests: read first, then write
    clear_mon(); rd_base = 24'h004240; wr_base = 24'h0001C0;
    wr_req = 1'b1; wr_row = 8'd7; rd_req = 1'b1; rd_row = 8'd9;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    run_until(1'b1, 400);
    chk("both_rd_first", 64'(first_rd_cmd >= 0 && first_rd_cmd < first_wr_beat), 64'(1));
    chk("both_rd_done", 64'(rd_dones), 64'(1));
    chk("both_wr_beats", 64'(wr_beats), 64'(64));
    chk("both_no_ovr", 64'(st_dout), 64'(0));

    // Write with random backpressure
    clear_mon(); wr_base = 24'h000080; rnd_ready = 1'b1;
    pulse_wr(8'd2);
    run_until(1'b1, 2000);
    rnd_ready = 1'b0;
    chk("rnd_wr_beats", 64'(wr_beats), 64'(64));
    chk("rnd_wr_bursts", 64'(wr_bb), 64'(8));

    // Duplicate read request during an active read
    clear_mon(); rd_base = 24'h004040;
    pulse_rd(8'd1);
    repeat (10) tick();
    pulse_rd(8'd1);
    chk("rd_ovr", 64'(st_dout), 64'h01);
    run_until(1'b0, 300);
    chk("ovr_rd_beats", 64'(lw_cnt), 64'(64));
    repeat (20) tick();
    chk("ovr_rd_cmds", 64'(rd_cmds), 64'(8));
    chk("ovr_rd_done", 64'(rd_dones), 64'(1));

    // Reset after three read beats; remaining beats must be ignored
    clear_mon(); rd_base = 24'h004100;
    pulse_rd(8'd4);
    n = 0;
    while (lw_cnt < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_wait_timeout", 64'(n < 200), 64'(1));
    rst = 1'b1; init_done = 1'b0;
    tick();
    chk_reset();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("abort_lw_cnt", 64'(lw_cnt), 64'(3));
    chk("abort_no_done", 64'(rd_dones), 64'(0));

    // Held in WAIT_INIT until calibration completes
    clear_mon(); wr_base = 24'h000180;
    pulse_wr(8'd6);
    repeat (10) tick();
    chk("init_hold_busy", 64'(busy_cyc), 64'(0));
    chk("init_hold_beats", 64'(wr_beats), 64'(0));
    init_done = 1'b1;
    run_until(1'b1, 200);
    chk("init_wr_beats", 64'(wr_beats), 64'(64));

    // Frame toggle on vs rising edge moves writes to frame 1
    vs = 1'b1; tick(); vs = 1'b0; tick();
    clear_mon(); wr_base = 24'h004040;
    pulse_wr(8'd1);
    run_until(1'b1, 200);
    chk("frm1_wr_beats", 64'(wr_beats), 64'(64));
    chk("frm1_wr_bursts", 64'(wr_bb), 64'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
